apb_arbiter: RTL and testbench
==============================

// Module: apb_arbiter
// PURPOSE
//  Two-requester APB arbiter that shares one APB target bus (apbAddrSt/apbDataSt) between two initiators.
//  Typical use: the CPU initiator and a second initiator (debug/DMA) in front of apbDecode.
//  Round-robin fairness. One transfer in flight at a time.
//  Fully registered toward the target, so the decode fabric sees clean APB setup/access phases.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max ACCESS cycles before forced error (used only with APB_ARB_TIMEOUT_EN)
//  TO_W            $clog2(TIMEOUT_CYCLES+1)  timeout counter width (derived, localparam)
// PORTS
//  clk        input   1       single clock
//  rst_n      input   1       asynchronous active-low reset
//  apbM0      apb_if  intf    initiator 0 side (arbiter acts as target); addr_t=apbAddrSt, data_t=apbDataSt
//  apbM1      apb_if  intf    initiator 1 side (arbiter acts as target); same types
//  apbS       apb_if  intf    shared target bus (arbiter acts as initiator)
//  grant_o    output  1       index of master owning the current/last transfer
//  busy_o     output  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; last_gnt=1; apbS.psel/penable/pwrite=0; apbS.paddr/pwdata=0.
//    Both masters: pready=0, prdata=0, pslverr=0. grant_o=0; busy_o=0.
//    A reset mid-transfer drops the transfer silently; the target sees psel fall.
//  FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  IDLE: request = apbMx.psel (penable ignored).
//    One requester: grant it.
//    Both requesters: grant the index != last_gnt.
//    On grant, register paddr/pwrite/pwdata from the winner; set grant_o; go to SETUP.
//  SETUP (1 cycle): apbS.psel=1, penable=0, with the captured fields.
//  ACCESS: apbS.psel=1, penable=1. Stay while apbS.pready=0.
//    On pready=1: capture prdata/pslverr, drop psel/penable, go to RESP.
//  RESP (1 cycle):
//    Granted master gets pready=1 with the captured prdata/pslverr.
//    last_gnt := grant_o. Next cycle goes to IDLE.
//  Outside RESP, both masters' pready=0. prdata/pslverr hold 0 outside RESP.
//  Latency: psel seen in cycle N, zero-wait target -> SETUP N+1, ACCESS N+2, master pready N+3.
//    Each target wait state adds 1 cycle.
//  The non-granted master's request stays pending (APB requires psel held). It is evaluated in the next IDLE.
//    Max wait for a requester is one foreign transfer.
//  A master is never re-granted in its own RESP cycle: its psel is still high there, but IDLE samples the next cycle.
//  The arbiter never modifies pwdata/paddr. pwrite=0 captures are reads; pwdata is still forwarded.
// CONFIGURATION
//  APB_ARB_TIMEOUT_EN defined:
//    A TO_W counter clears on SETUP and increments each ACCESS cycle without pready.
//    At TIMEOUT_CYCLES it drops apbS psel/penable and goes to RESP with pslverr=1, prdata=0.
//    A late target pready after abort is ignored.
//  APB_ARB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for pready.
// STRUCTURE
//  mixed_package gains:
//    typedef enum logic [1:0] {ARB_IDLE, ARB_SETUP, ARB_ACCESS, ARB_RESP} apbArbStateT
//    localparam APB_ARB_NUM_M = 2
//  Reuses apbAddrSt/apbDataSt.
//  Sub-module rr_arb2: combinational 2-way round-robin picker.
//    Inputs: req[1:0], last_gnt. Outputs: gnt_vld, gnt_idx.
//  The FSM, capture registers and timeout stay in apb_arbiter.
// TESTING
//  1. Only M0 writes paddr=0x10, pwdata=0xA5, target pready tied 1
//     -> apbS.psel@N+1, penable@N+2, M0 pready@N+3; M1 pready stays 0.
//  2. M0 and M1 both assert psel in the first cycle after reset
//     -> M0 served first (grant_o=0), then M1 (grant_o=1); each completes once.
//  3. Both masters request continuously for 6 transfers
//     -> grant_o sequence 0,1,0,1,0,1; busy_o drops for exactly 1 IDLE cycle between transfers.
//  4. M1 reads 0x24, target inserts 5 wait states, returns prdata=0xDEAD, pslverr=1
//     -> M1 pready at N+8 with prdata=0xDEAD, pslverr=1.
//  5. APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, target never ready
//     -> after 8 ACCESS cycles: apbS.psel=0, M0 pready=1, pslverr=1, prdata=0.
//     Build without macro: still in ACCESS after 100 cycles.
//  6. rst_n pulsed low during ACCESS
//     -> all outputs 0 asynchronously, state IDLE; a fresh M1 read after release completes normally.

Source files
------------

// File: rtl/apb_arbiter_pkg.sv
// apb_arbiter_pkg
//   Shared types and constants for the two-initiator APB arbiter.
//   apbAddrSt / apbDataSt : APB address and data word types
//   apbArbStateT          : arbiter FSM state encoding
//   APB_ARB_NUM_M         : number of initiators served by the arbiter
package apb_arbiter_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef logic [APB_ADDR_W-1:0] apbAddrSt;
  typedef logic [APB_DATA_W-1:0] apbDataSt;

  localparam int unsigned APB_ARB_NUM_M = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS,
    ARB_RESP
  } apbArbStateT;

endpackage

// File: rtl/apb_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin picker.
//   req_i[1:0]  : request from initiator 0 / 1
//   last_gnt_i  : index that owned the previous completed transfer
//   gnt_vld_o   : at least one request present
//   gnt_idx_o   : winning index (the one that did not go last on a tie)
module rr_arb2
  import apb_arbiter_pkg::*;
(
  input  logic [APB_ARB_NUM_M-1:0] req_i,
  input  logic                     last_gnt_i,
  output logic                     gnt_vld_o,
  output logic                     gnt_idx_o
);

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = 1'b0;
    if (&req_i) begin
      gnt_idx_o = ~last_gnt_i;
    end else begin
      gnt_idx_o = req_i[1];
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter
//   Shares one APB target bus between two APB initiators with round-robin
//   fairness; one transfer in flight, everything toward the target registered.
//   Optional feature macro: APB_ARB_TIMEOUT_EN (ACCESS-phase timeout abort).
// Ports
//   clk, rst_n               : clock, asynchronous active-low reset
//   m0_* / m1_*              : initiator-side APB (arbiter acts as target)
//   s_*                      : shared target-side APB (arbiter acts as initiator)
//   grant_o                  : index of initiator owning the current/last transfer
//   busy_o                   : FSM is not in IDLE
// Parameters
//   TIMEOUT_CYCLES           : ACCESS cycles before forced error (timeout build only)
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // initiator 0
  input  logic                  m0_psel_i,
  input  logic                  m0_penable_i,
  input  logic                  m0_pwrite_i,
  input  logic [APB_ADDR_W-1:0] m0_paddr_i,
  input  logic [APB_DATA_W-1:0] m0_pwdata_i,
  output logic                  m0_pready_o,
  output logic [APB_DATA_W-1:0] m0_prdata_o,
  output logic                  m0_pslverr_o,
  // initiator 1
  input  logic                  m1_psel_i,
  input  logic                  m1_penable_i,
  input  logic                  m1_pwrite_i,
  input  logic [APB_ADDR_W-1:0] m1_paddr_i,
  input  logic [APB_DATA_W-1:0] m1_pwdata_i,
  output logic                  m1_pready_o,
  output logic [APB_DATA_W-1:0] m1_prdata_o,
  output logic                  m1_pslverr_o,
  // shared target bus
  output logic                  s_psel_o,
  output logic                  s_penable_o,
  output logic                  s_pwrite_o,
  output logic [APB_ADDR_W-1:0] s_paddr_o,
  output logic [APB_DATA_W-1:0] s_pwdata_o,
  input  logic                  s_pready_i,
  input  logic [APB_DATA_W-1:0] s_prdata_i,
  input  logic                  s_pslverr_i,
  // status
  output logic                  grant_o,
  output logic                  busy_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  apbArbStateT state_q;
  logic        last_gnt_q;
  logic        grant_q;

  logic        s_psel_q;
  logic        s_penable_q;
  logic        s_pwrite_q;
  apbAddrSt    s_paddr_q;
  apbDataSt    s_pwdata_q;

  logic        m0_pready_q;
  apbDataSt    m0_prdata_q;
  logic        m0_pslverr_q;
  logic        m1_pready_q;
  apbDataSt    m1_prdata_q;
  logic        m1_pslverr_q;

  logic        gnt_vld;
  logic        gnt_idx;

  logic        resp_done_d;
  apbDataSt    resp_rdata_d;
  logic        resp_err_d;

  // Initiator penable plays no part in arbitration: psel alone is the request.
  logic        unused_penable;
  assign unused_penable = m0_penable_i ^ m1_penable_i;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  rr_arb2 u_rr_arb2 (
    .req_i      ({m1_psel_i, m0_psel_i}),
    .last_gnt_i (last_gnt_q),
    .gnt_vld_o  (gnt_vld),
    .gnt_idx_o  (gnt_idx)
  );

  // End-of-ACCESS condition and the response to hand back. A timeout abort
  // looks like a normal completion carrying an error and zero data.
  always_comb begin
    resp_done_d  = s_pready_i;
    resp_rdata_d = s_prdata_i;
    resp_err_d   = s_pslverr_i;
`ifdef APB_ARB_TIMEOUT_EN
    if (!s_pready_i && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
      resp_done_d  = 1'b1;
      resp_rdata_d = '0;
      resp_err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_gnt_q   <= 1'b1;
      grant_q      <= 1'b0;
      s_psel_q     <= 1'b0;
      s_penable_q  <= 1'b0;
      s_pwrite_q   <= 1'b0;
      s_paddr_q    <= '0;
      s_pwdata_q   <= '0;
      m0_pready_q  <= 1'b0;
      m0_prdata_q  <= '0;
      m0_pslverr_q <= 1'b0;
      m1_pready_q  <= 1'b0;
      m1_prdata_q  <= '0;
      m1_pslverr_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (gnt_vld) begin
            grant_q    <= gnt_idx;
            s_paddr_q  <= gnt_idx ? m1_paddr_i  : m0_paddr_i;
            s_pwdata_q <= gnt_idx ? m1_pwdata_i : m0_pwdata_i;
            s_pwrite_q <= gnt_idx ? m1_pwrite_i : m0_pwrite_i;
            s_psel_q   <= 1'b1;
            state_q    <= ARB_SETUP;
          end
        end
        ARB_SETUP: begin
          s_penable_q <= 1'b1;
          state_q     <= ARB_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          to_cnt_q    <= '0;
`endif
        end
        ARB_ACCESS: begin
          if (resp_done_d) begin
            s_psel_q    <= 1'b0;
            s_penable_q <= 1'b0;
            if (grant_q) begin
              m1_pready_q  <= 1'b1;
              m1_prdata_q  <= resp_rdata_d;
              m1_pslverr_q <= resp_err_d;
            end else begin
              m0_pready_q  <= 1'b1;
              m0_prdata_q  <= resp_rdata_d;
              m0_pslverr_q <= resp_err_d;
            end
            state_q <= ARB_RESP;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        ARB_RESP: begin
          // Returning to IDLE (not straight to SETUP) keeps the finishing
          // initiator's still-high psel from being re-granted this cycle.
          m0_pready_q  <= 1'b0;
          m0_prdata_q  <= '0;
          m0_pslverr_q <= 1'b0;
          m1_pready_q  <= 1'b0;
          m1_prdata_q  <= '0;
          m1_pslverr_q <= 1'b0;
          last_gnt_q   <= grant_q;
          state_q      <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign s_psel_o     = s_psel_q;
  assign s_penable_o  = s_penable_q;
  assign s_pwrite_o   = s_pwrite_q;
  assign s_paddr_o    = s_paddr_q;
  assign s_pwdata_o   = s_pwdata_q;

  assign m0_pready_o  = m0_pready_q;
  assign m0_prdata_o  = m0_prdata_q;
  assign m0_pslverr_o = m0_pslverr_q;
  assign m1_pready_o  = m1_pready_q;
  assign m1_prdata_o  = m1_prdata_q;
  assign m1_pslverr_o = m1_pslverr_q;

  assign grant_o      = grant_q;
  assign busy_o       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter
//   Self-checking bench for apb_arbiter: initiator BFMs with a per-initiator
//   response scoreboard, a programmable target model, a table of single
//   transfers and hand-written arbitration / timeout / reset sequences.
//   Honours APB_ARB_TIMEOUT_EN (timeout build runs with TIMEOUT_CYCLES=8).
module tb_apb_arbiter;
  import apb_arbiter_pkg::*;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TB_TO = 8;
`else
  localparam int unsigned TB_TO = 256;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
  logic [31:0] m0_paddr, m0_pwdata, m0_prdata;
  logic        m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
  logic [31:0] m1_paddr, m1_pwdata, m1_prdata;
  logic        s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic [31:0] s_paddr, s_pwdata, s_prdata;
  logic        grant, busy;

  apb_arbiter #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_psel_i(m0_psel), .m0_penable_i(m0_penable), .m0_pwrite_i(m0_pwrite),
    .m0_paddr_i(m0_paddr), .m0_pwdata_i(m0_pwdata),
    .m0_pready_o(m0_pready), .m0_prdata_o(m0_prdata), .m0_pslverr_o(m0_pslverr),
    .m1_psel_i(m1_psel), .m1_penable_i(m1_penable), .m1_pwrite_i(m1_pwrite),
    .m1_paddr_i(m1_paddr), .m1_pwdata_i(m1_pwdata),
    .m1_pready_o(m1_pready), .m1_prdata_o(m1_prdata), .m1_pslverr_o(m1_pslverr),
    .s_psel_o(s_psel), .s_penable_o(s_penable), .s_pwrite_o(s_pwrite),
    .s_paddr_o(s_paddr), .s_pwdata_o(s_pwdata),
    .s_pready_i(s_pready), .s_prdata_i(s_prdata), .s_pslverr_i(s_pslverr),
    .grant_o(grant), .busy_o(busy)
  );

  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- target model ----------------
  logic        tgt_never = 1'b0;
  logic        tgt_slverr = 1'b0;
  logic        tgt_fixed = 1'b0;
  logic [31:0] tgt_rdata = '0;
  int          tgt_waits = 0;
  int          tcnt = 0;

  function automatic logic [31:0] tgt_fn(input logic [31:0] a);
    return {16'hC0DE, a[15:0] ^ 16'h1111};
  endfunction

  always @(posedge clk) begin
    if (s_psel && s_penable && !s_pready) tcnt <= tcnt + 1;
    else tcnt <= 0;
  end
  assign s_pready  = s_psel && s_penable && !tgt_never && (tcnt >= tgt_waits);
  assign s_prdata  = s_pready ? (tgt_fixed ? tgt_rdata : tgt_fn(s_paddr)) : 32'hBAD0BAD0;
  assign s_pslverr = s_pready & tgt_slverr;

  // ---------------- initiator BFMs + scoreboard ----------------
  typedef struct {
    int          launch;
    int          lat;
    logic [31:0] rdata;
    logic        slverr;
  } exp_t;

  exp_t sbq0[$];
  exp_t sbq1[$];

  logic        mp_psel[2], mp_pen[2], mp_write[2];
  logic [31:0] mp_addr[2], mp_wdata[2];
  int          launched[2], done[2];
  int          req_total[2], cfg_lat[2], cfg_stride[2];
  logic        cfg_write[2];
  logic [31:0] cfg_addr[2], cfg_wdata[2];

  assign m0_psel = mp_psel[0];  assign m0_penable = mp_pen[0];  assign m0_pwrite = mp_write[0];
  assign m0_paddr = mp_addr[0]; assign m0_pwdata = mp_wdata[0];
  assign m1_psel = mp_psel[1];  assign m1_penable = mp_pen[1];  assign m1_pwrite = mp_write[1];
  assign m1_paddr = mp_addr[1]; assign m1_pwdata = mp_wdata[1];

  task automatic launch(input int m);
    exp_t e;
    mp_psel[m]  = 1'b1;
    mp_pen[m]   = 1'b0;
    mp_write[m] = cfg_write[m];
    mp_addr[m]  = cfg_addr[m] + 32'(cfg_stride[m] * launched[m]);
    mp_wdata[m] = cfg_wdata[m] + 32'(cfg_stride[m] * launched[m]);
    e.launch = cyc;
    e.lat    = cfg_lat[m];
    e.rdata  = tgt_never ? 32'h0 : (tgt_fixed ? tgt_rdata : tgt_fn(mp_addr[m]));
    e.slverr = tgt_never ? 1'b1 : tgt_slverr;
    if (m == 0) sbq0.push_back(e);
    else sbq1.push_back(e);
    launched[m]++;
  endtask

  task automatic check_resp(input int m, input logic [31:0] rd, input logic er);
    exp_t e;
    int   sz;
    sz = (m == 0) ? sbq0.size() : sbq1.size();
    if (sz == 0) begin
      chk($sformatf("m%0d_unexpected_pready", m), 32'd1, 32'd0);
    end else begin
      if (m == 0) e = sbq0.pop_front();
      else e = sbq1.pop_front();
      chk($sformatf("m%0d_prdata", m), rd, e.rdata);
      chk($sformatf("m%0d_pslverr", m), 32'(er), 32'(e.slverr));
      if (e.lat >= 0) chk($sformatf("m%0d_latency", m), 32'(cyc - e.launch), 32'(e.lat));
    end
  endtask

  always @(negedge clk) begin : bfm
    logic        pr;
    logic [31:0] rd;
    logic        er;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        mp_psel[m]  = 1'b0;
        mp_pen[m]   = 1'b0;
        launched[m] = req_total[m];
      end
      sbq0.delete();
      sbq1.delete();
    end else begin
      for (int m = 0; m < 2; m++) begin
        pr = (m == 0) ? m0_pready : m1_pready;
        rd = (m == 0) ? m0_prdata : m1_prdata;
        er = (m == 0) ? m0_pslverr : m1_pslverr;
        if (pr) begin
          check_resp(m, rd, er);
          done[m]++;
        end
        if (pr || !mp_psel[m]) begin
          if (launched[m] < req_total[m]) launch(m);
          else begin
            mp_psel[m] = 1'b0;
            mp_pen[m]  = 1'b0;
          end
        end else begin
          mp_pen[m] = 1'b1;
        end
      end
    end
  end

  // Owner of every transfer as it enters SETUP.
  logic glog[$];
  always @(negedge clk) if (rst_n && s_psel && !s_penable) glog.push_back(grant);

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int m, input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done[m] < target && n < budget) begin
      step();
      n++;
    end
    chk({name, "_completes"}, 32'(done[m] >= target), 32'd1);
  endtask

  task automatic set_cfg(input int m, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stride, input int lat);
    cfg_write[m]  = wr;
    cfg_addr[m]   = addr;
    cfg_wdata[m]  = wdata;
    cfg_stride[m] = stride;
    cfg_lat[m]    = lat;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        slverr;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    int d, g0, n, idle, run, maxrun, d0, d1;
    for (int m = 0; m < 2; m++) begin
      req_total[m] = 0; launched[m] = 0; done[m] = 0;
      mp_addr[m] = '0; mp_wdata[m] = '0; mp_write[m] = 1'b0;
      set_cfg(m, 1'b0, '0, '0, 0, -1);
    end

    vecs[0] = '{m:0, wr:1'b1, addr:32'h10,       wdata:32'hA5,       waits:0, rdata:32'h0,        slverr:1'b0, lat:3};
    vecs[1] = '{m:0, wr:1'b0, addr:32'h3FC,      wdata:32'h11112222, waits:2, rdata:32'h12345678, slverr:1'b0, lat:5};
    vecs[2] = '{m:1, wr:1'b1, addr:32'hFFFFFFFC, wdata:32'hFFFFFFFF, waits:1, rdata:32'hCAFEF00D, slverr:1'b0, lat:4};
    vecs[3] = '{m:0, wr:1'b1, addr:32'h0,        wdata:32'h0,        waits:0, rdata:32'h0000BEEF, slverr:1'b1, lat:3};
    vecs[4] = '{m:1, wr:1'b0, addr:32'h24,       wdata:32'h55AA55AA, waits:5, rdata:32'hDEAD,     slverr:1'b1, lat:8};

    // Reset state
    repeat (3) @(posedge clk);
    step();
    chk("rst_s_psel", 32'(s_psel), 0);
    chk("rst_s_penable", 32'(s_penable), 0);
    chk("rst_s_paddr", s_paddr, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_m0_pready", 32'(m0_pready), 0);
    chk("rst_m1_prdata", m1_prdata, 0);

    // Both initiators request in the first cycle after reset: M0 then M1
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_cfg(0, 1'b0, 32'h100, 32'h0, 4, 3);
    set_cfg(1, 1'b0, 32'h200, 32'h0, 4, -1);
    g0 = glog.size();
    req_total[0]++; req_total[1]++;
    wait_done(1, 1, 30, "both_after_reset");
    repeat (4) step();
    chk("both_after_reset_m0_count", 32'(done[0]), 1);
    chk("both_after_reset_m1_count", 32'(done[1]), 1);
    chk("both_after_reset_nxfers", 32'(glog.size() - g0), 2);
    chk("both_after_reset_first", (g0 < glog.size()) ? 32'(glog[g0]) : 32'hFFFF, 0);
    chk("both_after_reset_second", (g0 + 1 < glog.size()) ? 32'(glog[g0+1]) : 32'hFFFF, 1);

    // Single-initiator transfers from the table
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tgt_fixed  = 1'b1;
      tgt_rdata  = vecs[i].rdata;
      tgt_slverr = vecs[i].slverr;
      tgt_waits  = vecs[i].waits;
      set_cfg(vecs[i].m, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, vecs[i].lat);
      d = done[vecs[i].m];
      req_total[vecs[i].m]++;
      step();  // request launched, arbiter in IDLE
      step();  // SETUP
      chk($sformatf("v%0d_setup_psel", i), 32'(s_psel), 1);
      chk($sformatf("v%0d_setup_penable", i), 32'(s_penable), 0);
      chk($sformatf("v%0d_paddr", i), s_paddr, vecs[i].addr);
      chk($sformatf("v%0d_pwdata", i), s_pwdata, vecs[i].wdata);
      chk($sformatf("v%0d_pwrite", i), 32'(s_pwrite), 32'(vecs[i].wr));
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].m));
      step();  // ACCESS
      chk($sformatf("v%0d_access_penable", i), 32'(s_penable), 1);
      wait_done(vecs[i].m, d + 1, 20, $sformatf("v%0d", i));
      chk($sformatf("v%0d_other_pready", i), 32'(vecs[i].m == 0 ? m1_pready : m0_pready), 0);
      chk($sformatf("v%0d_resp_psel", i), 32'(s_psel), 0);
      step();
      chk($sformatf("v%0d_idle_busy", i), 32'(busy), 0);
    end

    // Continuous requests from both: strict alternation, one IDLE cycle between
    @(posedge clk); #1;
    tgt_fixed = 1'b0; tgt_waits = 0; tgt_slverr = 1'b0;
    set_cfg(0, 1'b1, 32'h1000, 32'h7000, 4, -1);
    set_cfg(1, 1'b0, 32'h2000, 32'h8000, 4, -1);
    g0 = glog.size(); d0 = done[0]; d1 = done[1];
    req_total[0] += 3; req_total[1] += 3;
    n = 0; idle = 0; run = 0; maxrun = 0;
    while ((done[0] < d0 + 3 || done[1] < d1 + 3) && n < 80) begin
      step();
      n++;
      if (glog.size() > g0) begin
        if (!busy) begin
          idle++; run++;
          if (run > maxrun) maxrun = run;
        end else run = 0;
      end
    end
    chk("rr6_completes", 32'((done[0] >= d0 + 3) && (done[1] >= d1 + 3)), 1);
    chk("rr6_nxfers", 32'(glog.size() - g0), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr6_grant%0d", i), (g0 + i < glog.size()) ? 32'(glog[g0+i]) : 32'hFFFF, 32'(i % 2));
    chk("rr6_idle_cycles", 32'(idle), 5);
    chk("rr6_idle_run", 32'(maxrun), 1);

    // Target never ready
    step();
    @(posedge clk); #1;
    tgt_never = 1'b1;
    d = done[0];
`ifdef APB_ARB_TIMEOUT_EN
    set_cfg(0, 1'b0, 32'h40, 32'h0, 0, 2 + int'(TB_TO));
    req_total[0]++;
    wait_done(0, d + 1, 40, "timeout");
    chk("timeout_s_psel", 32'(s_psel), 0);
    chk("timeout_m0_pready", 32'(m0_pready), 1);
    chk("timeout_m1_pready", 32'(m1_pready), 0);
    step();
    chk("timeout_idle_busy", 32'(busy), 0);
    // Fresh never-ready transfer, to be cut by reset in ACCESS
    @(posedge clk); #1;
    req_total[0]++;
    step(); step(); step();
`else
    set_cfg(0, 1'b0, 32'h40, 32'h0, 0, -1);
    req_total[0]++;
    repeat (100) step();
    chk("hang_s_psel", 32'(s_psel), 1);
    chk("hang_s_penable", 32'(s_penable), 1);
    chk("hang_busy", 32'(busy), 1);
    chk("hang_no_response", 32'(done[0]), 32'(d));
`endif

    // Asynchronous reset during ACCESS
    chk("pre_reset_in_access", 32'(s_psel && s_penable), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s_psel", 32'(s_psel), 0);
    chk("arst_s_penable", 32'(s_penable), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_m0_pready", 32'(m0_pready), 0);
    tgt_never = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tgt_fixed = 1'b1; tgt_rdata = 32'h600DF00D; tgt_waits = 0; tgt_slverr = 1'b0;
    set_cfg(1, 1'b0, 32'h24, 32'h0, 0, 3);
    d = done[1];
    req_total[1]++;
    wait_done(1, d + 1, 20, "post_reset_m1");
    chk("post_reset_grant", (glog.size() > 0) ? 32'(glog[glog.size()-1]) : 32'hFFFF, 1);
    step();
    chk("post_reset_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
